// File: rtl/pcle_pkg.sv
// pcle_pkg: shared width, FSM states and datapath control encodings for the pcle counter
package pcle_pkg;
    localparam int WIDTH = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [1:0] CTL_CLR  = 2'd0;
    localparam logic [1:0] CTL_LOAD = 2'd1;
    localparam logic [1:0] CTL_INC  = 2'd2;
    localparam logic [1:0] CTL_HOLD = 2'd3;
endpackage

// File: rtl/pcle_next.sv
// pcle_next: combinational next-state of the loadable counter datapath
module pcle_next #(
    parameter int WIDTH = pcle_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] next,
    output logic             carry
);
    logic [WIDTH:0] sum;
    assign sum   = {1'b0, cnt} + (WIDTH+1)'(1);
    assign next  = load ? din : (en && !clr) ? sum[WIDTH-1:0] : '0;
    assign carry = !load && en && !clr && sum[WIDTH];
endmodule

// File: rtl/pcle_ctrl.sv
// pcle_ctrl: arbitrates load/burst requests and sequences the counter datapath
module pcle_ctrl #(
    parameter int WIDTH = pcle_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_req,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             run_valid,
    output logic             run_ready,
    input  logic [WIDTH-1:0] run_len,
    input  logic             run_wrap,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             tc,
    output logic             sat
);
    import pcle_pkg::*;
    state_t state, state_n;
    logic [WIDTH-1:0] rem, rem_n, din, nxt;
    logic [1:0] ctl;
    logic wrap_q, wrap_n, sat_n, carry;
    always_comb begin
        ctl     = CTL_HOLD;
        state_n = state;
        rem_n   = rem;
        wrap_n  = wrap_q;
        sat_n   = sat;
        if (clr_req) begin
            ctl     = CTL_CLR;
            state_n = IDLE;
            rem_n   = '0;
            sat_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_valid) begin
                        ctl = CTL_LOAD;
                    end else if (run_valid) begin
                        rem_n   = run_len;
                        wrap_n  = run_wrap;
                        sat_n   = 1'b0;
                        state_n = (run_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (&cnt && !wrap_q) begin
                        sat_n   = 1'b1;
                        state_n = DONE;
                    end else begin
                        ctl     = CTL_INC;
                        rem_n   = rem - WIDTH'(1);
                        state_n = (rem == WIDTH'(1)) ? DONE : RUN;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
    // the datapath clears when idle, so holding means reloading the current value
    assign din = (ctl == CTL_LOAD) ? ld_data : cnt;
    pcle_next #(.WIDTH(WIDTH)) u_next (
        .din   (din),
        .load  (ctl == CTL_LOAD || ctl == CTL_HOLD),
        .en    (ctl == CTL_INC),
        .clr   (ctl == CTL_CLR),
        .cnt   (cnt),
        .next  (nxt),
        .carry (carry)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            wrap_q <= 1'b0;
            tc     <= 1'b0;
            sat    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= nxt;
            rem    <= rem_n;
            wrap_q <= wrap_n;
            tc     <= carry;
            sat    <= sat_n;
        end
    end
    assign ld_ready  = (state == IDLE) && !clr_req && !rst;
    assign run_ready = ld_ready && !ld_valid;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
endmodule
